seven_seg_mux_display: RTL and testbench

//   Parametrised, time-multiplexed hex display driver for NUM_DIGITS common-anode

---
 rtl/seven_seg_mux_display.sv | 140 ++++++++++++++
 tb/tb_seven_seg_mux_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux_display.sv
// Time-multiplexed hex driver for common-anode seven-segment digits with tear-free frame commit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_mux_display #(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 24000,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    frame_start
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
   logic                    pend_vld_q, pend_vld_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [6:0]              seg_d;

   logic       slot_end;
   logic       boundary;
   logic       commit;
   logic       dead;
   logic [3:0] nib;
   logic       blank_lead;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end = (cnt_q == CNT_LAST);
      boundary = slot_end && (idx_q == IDX_LAST);
      commit   = boundary && (pend_vld_q || load);

      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // A load landing on the boundary bypasses pend and commits straight away.
      disp_d     = commit ? (load ? digits : pend_q) : disp_q;
      pend_d     = load ? digits : pend_q;
      pend_vld_d = commit ? 1'b0 : (load ? 1'b1 : pend_vld_q);
   end

   always_comb begin
      nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib = disp_q[4*i +: 4];
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;
   logic                  zero_run;

   // lz[i] set when every nibble from the top down to i is zero.
   always_comb begin
      lz       = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
         lz[i]    = zero_run;
      end
      blank_lead = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            blank_lead = lz[i];
         end
      end
   end
`else
   always_comb begin
      blank_lead = 1'b0;
   end
`endif

   always_comb begin
      dead  = (cnt_q < DEAD_LIM);
      an_d  = dead ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_d = (dead || blank_lead) ? 7'h7F : hex7(nib);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         disp_q      <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         an          <= '1;
         seg         <= 7'h7F;
         frame_start <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         disp_q      <= disp_d;
         pend_q      <= pend_d;
         pend_vld_q  <= pend_vld_d;
         an          <= an_d;
         seg         <= seg_d;
         frame_start <= commit;
      end
   end

endmodule

// File: tb/tb_seven_seg_mux_display.sv
// Scoreboard bench for seven_seg_mux_display (2 digits, 4-cycle slots, 1 dead cycle).
// Define LEADING_ZERO_BLANK_EN for both DUT and bench to exercise leading-zero blanking.
module tb_seven_seg_mux_display;

   localparam int N = 2;
   localparam int R = 4;
   localparam int D = 1;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       load;
   logic [7:0] digits;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame_start;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [6:0] hex_tab [16];
   int         errors = 0;
   int         checks = 0;

   // Reference model state: cycles since reset release, shown and pending values.
   int         k = 0;
   logic [7:0] shown = '0;
   logic [7:0] pend = '0;
   logic       pvld = 1'b0;

   seven_seg_mux_display #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(R),
      .DEAD_CYCLES(D)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .digits     (digits),
      .an         (an),
      .seg        (seg),
      .frame_start(frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input logic rst_n, input logic ld, input logic [7:0] dg);
      exp_t       e;
      int         pos;
      int         slot;
      logic [7:0] upper;
      logic       bnd;
      @(negedge clk);
      reset  = rst_n;
      load   = ld;
      digits = dg;
      e.an   = 2'b11;
      e.seg  = 7'h7F;
      e.fs   = 1'b0;
      if (!rst_n) begin
         k     = 0;
         shown = '0;
         pend  = '0;
         pvld  = 1'b0;
      end else begin
         pos  = k % R;
         slot = (k / R) % N;
         if (pos >= D) begin
            e.an  = ~(2'b01 << slot);
            upper = shown >> (4 * slot);
            e.seg = hex_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
            if (slot > 0 && upper == 8'h00) e.seg = 7'h7F;
`endif
         end
         bnd = (pos == R - 1) && (slot == N - 1);
         if (bnd && (pvld || ld)) begin
            e.fs  = 1'b1;
            shown = ld ? dg : pend;
            pvld  = 1'b0;
         end else if (ld) begin
            pend = dg;
            pvld = 1'b1;
         end
         k++;
      end
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (an !== mon_e.an) begin
            errors++;
            $display("FAIL an t=%0t got=%b want=%b", $time, an, mon_e.an);
         end
         checks++;
         if (seg !== mon_e.seg) begin
            errors++;
            $display("FAIL seg t=%0t got=%b want=%b", $time, seg, mon_e.seg);
         end
         checks++;
         if (frame_start !== mon_e.fs) begin
            errors++;
            $display("FAIL frame_start t=%0t got=%b want=%b", $time, frame_start, mon_e.fs);
         end
         checks++;
         if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL an_onehot t=%0t got=%b want=at most one low", $time, an);
         end
      end
   end

   initial begin
      logic [7:0] dg;
      hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
      hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
      hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
      hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
      hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
      hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
      hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
      hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
      reset  = 1'b0;
      load   = 1'b0;
      digits = '0;

      repeat (3) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h3A);
      repeat (16) step(1'b1, 1'b0, 8'h00);
      // Mid-frame load must not tear the frame currently showing 3A.
      step(1'b1, 1'b1, 8'h12);
      repeat (12) step(1'b1, 1'b0, 8'h00);
      while ((k % (R * N)) != (R * N - 1)) step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hF0);
      repeat (16) step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h05);
      repeat (20) step(1'b1, 1'b0, 8'h00);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            repeat (2) step(1'b0, 1'b0, 8'h00);
         end else begin
            dg = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dg[7:4] = 4'h0;
            step(1'b1, ($urandom_range(0, 9) == 0), dg);
         end
      end
      repeat (4) step(1'b1, 1'b0, 8'h00);

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
